// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze/flush controls for the stage registers,
// saturating stall/flush perf counters and a sticky memory-wait watchdog.
module pipeline_hazard_ctrl #(
  parameter int INIT_FLUSH  = 2,
  parameter int MEM_TIMEOUT = 1023,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             forward_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             freeze_id,
  output logic             flush_id,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One counter serves both the init countdown and the memory-wait count.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + INIT_FLUSH + 2);
  localparam logic [WAIT_W-1:0] WAIT_ZERO   = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_MAX    = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] INIT_LOAD   = WAIT_W'(INIT_FLUSH - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              timeout_set_s;
  logic              mem_stall_s;
  logic              hazard_s;
  logic              branch_flush_s;
  logic              freeze_if_s;
  logic              flush_if_s;
  logic              freeze_id_s;
  logic              flush_id_s;
  logic              freeze_back_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              mem_timeout_r;

  // With forwarding only a load in EXE forces a bubble; without it any pending write does.
  function automatic logic hazard_chk(
    input logic       fwd,
    input logic       two,
    input logic [3:0] s1,
    input logic [3:0] s2,
    input logic [3:0] ed,
    input logic       ewb,
    input logic       emr,
    input logic [3:0] md,
    input logic       mwb
  );
    logic h;
    if (fwd) begin
      h = emr & ((s1 == ed) | (two & (s2 == ed)));
    end else begin
      h = (ewb & (s1 == ed)) | (mwb & (s1 == md)) |
          (two & ((ewb & (s2 == ed)) | (mwb & (s2 == md))));
    end
    return h;
  endfunction

  assign hazard_s    = hazard_chk(forward_en, two_src, src1, src2, exe_dest, exe_wb_en,
                                  exe_mem_r_en, mem_dest, mem_wb_en);
  assign mem_stall_s = mem_req & ~mem_ready;
  assign wait_inc_s  = (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : (wait_cnt_r + WAIT_ONE);

  // State and wait/init counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      wait_cnt_r <= INIT_LOAD;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state, counter and watchdog-trigger logic
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (wait_cnt_r == WAIT_ZERO) begin
          state_nxt_s = ST_RUN;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - WAIT_ONE;
        end
      end
      ST_RUN: begin
        if (mem_stall_s) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = WAIT_ONE;
          timeout_set_s  = (TIMEOUT_VAL <= WAIT_ONE);
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_req & mem_ready) begin
          state_nxt_s = ST_RUN;
        end else begin
          wait_cnt_nxt_s = wait_inc_s;
          timeout_set_s  = (wait_inc_s >= TIMEOUT_VAL);
        end
      end
      default: begin
        state_nxt_s    = ST_INIT;
        wait_cnt_nxt_s = INIT_LOAD;
      end
    endcase
  end

  // Freeze/flush outputs; a memory stall outranks a branch, which outranks a hazard
  always_comb begin
    freeze_if_s    = 1'b0;
    flush_if_s     = 1'b0;
    freeze_id_s    = 1'b0;
    flush_id_s     = 1'b0;
    freeze_back_s  = 1'b0;
    branch_flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_stall_s) begin
          freeze_if_s   = 1'b1;
          freeze_id_s   = 1'b1;
          freeze_back_s = 1'b1;
        end else if (branch_taken) begin
          flush_if_s     = 1'b1;
          flush_id_s     = 1'b1;
          branch_flush_s = 1'b1;
        end else if (hazard_s) begin
          freeze_if_s = 1'b1;
          flush_id_s  = 1'b1;
        end else begin
          freeze_if_s = 1'b0;
          flush_id_s  = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        freeze_if_s   = 1'b1;
        freeze_id_s   = 1'b1;
        freeze_back_s = 1'b1;
      end
      default: begin
        freeze_if_s = 1'b1;
        flush_if_s  = 1'b1;
        flush_id_s  = 1'b1;
      end
    endcase
  end

  // Saturating perf counters and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r   <= CNT_ZERO;
      flush_cnt_r   <= CNT_ZERO;
      mem_timeout_r <= 1'b0;
    end else begin
      if (freeze_if_s && (state_r != ST_INIT) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (branch_flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
      if (timeout_set_s) begin
        mem_timeout_r <= 1'b1;
      end
    end
  end

  assign freeze_if   = freeze_if_s;
  assign flush_if    = flush_if_s;
  assign freeze_id   = freeze_id_s;
  assign flush_id    = flush_id_s;
  assign freeze_back = freeze_back_s;
  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule
